// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
//   Central stall/flush sequencer for the 5-stage RV32I pipeline. It takes three
//   inputs: the load-use stall request, a taken redirect from EX and the
//   data-memory handshake. From these it drives the write enables and the
//   bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//   Priority: memory wait > redirect > load-use. A memory watchdog sets a
//   sticky error.
//   Optional feature: define PERF_COUNTERS_EN to build saturating stall/flush
//   cycle counters. Without it, stall_cycles and flush_cycles are tied to zero.
module pipeline_hazard_sequencer #(
  parameter int FLUSH_CYCLES = 2,   // IF/ID flush length after a redirect (1..3)
  parameter int MEM_TIMEOUT  = 255, // max consecutive wait cycles; 0 disables watchdog
  parameter int CNT_W        = 32   // perf counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  // Per-cycle decision. The outputs and the next-state logic are both derived from it.
  typedef enum logic [2:0] {
    A_NONE     = 3'd0,
    A_WAIT     = 3'd1,
    A_RELEASE  = 3'd2,
    A_REDIRECT = 3'd3,
    A_FLUSH    = 3'd4,
    A_LOAD_USE = 3'd5
  } action_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam int         WD_W         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);
  localparam logic       WD_ENABLE    = (MEM_TIMEOUT != 0);

  state_t          state;
  state_t          ret_state;   // state to resume after a memory wait
  logic [1:0]      flush_cnt;   // remaining FLUSH cycles
  logic [WD_W-1:0] wd_cnt;      // consecutive memory-wait cycles
  logic            mem_error_q;

  logic    mem_wait;
  logic    wd_expired;
  action_t action;

  assign mem_wait   = mem_req & ~mem_ready;
  assign wd_expired = WD_ENABLE && (state == S_MEM_WAIT) && (wd_cnt == WD_LIMIT);

  // Select this cycle's action from the current state and the hazard inputs, in priority order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    action = A_NONE;
    unique case (state)
      S_MEM_WAIT: begin
        // Redirect and load-use are ignored here. EX is frozen, so a redirect is presented again later.
        if (wd_expired || !mem_wait) action = A_RELEASE;
        else                         action = A_WAIT;
      end
      S_FLUSH: begin
        if (mem_wait)      action = A_WAIT;
        else if (redirect) action = A_REDIRECT;
        else               action = A_FLUSH;
      end
      default: begin
        if (mem_wait)            action = A_WAIT;
        else if (redirect)       action = A_REDIRECT;
        else if (load_use_stall) action = A_LOAD_USE;
        else                     action = A_NONE;
      end
    endcase
  end

  // Mealy pipeline controls. While reset is asserted they are forced to the frozen, all-NOP values.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else begin
      unique case (action)
        A_WAIT: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
        end
        A_REDIRECT: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        A_FLUSH: begin
          ifid_flush = 1'b1;
        end
        A_LOAD_USE: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ; // A_NONE and A_RELEASE keep the free-running defaults
      endcase
    end
  end

  // Sequencer FSM: state, return state, flush countdown, watchdog and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state       <= S_RUN;
      ret_state   <= S_RUN;
      flush_cnt   <= 2'd0;
      wd_cnt      <= '0;
      mem_error_q <= 1'b0;
    end else begin
      unique case (action)
        A_WAIT: begin
          if (state != S_MEM_WAIT) ret_state <= state;
          state <= S_MEM_WAIT;
          if (WD_ENABLE) wd_cnt <= wd_cnt + 1'b1;
        end
        A_RELEASE: begin
          wd_cnt <= '0;
          if (wd_expired) begin
            // A timed-out access abandons any pending flush and restarts in RUN.
            mem_error_q <= 1'b1;
            state       <= S_RUN;
            flush_cnt   <= 2'd0;
          end else begin
            state <= ret_state;
          end
        end
        A_REDIRECT: begin
          flush_cnt <= FLUSH_RELOAD;
          state     <= (FLUSH_RELOAD != 2'd0) ? S_FLUSH : S_RUN;
        end
        A_FLUSH: begin
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt <= 2'd1) state <= S_RUN;
        end
        default: ; // RUN idle and load-use bubbles leave the sequencer state untouched
      endcase
    end
  end

  assign mem_error = mem_error_q;

`ifdef PERF_COUNTERS_EN
  // Saturating perf counters for stall cycles (PC held) and flush cycles (IF/ID squashed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_we && (stall_cycles != {CNT_W{1'b1}}))      stall_cycles <= stall_cycles + 1'b1;
      if (ifid_flush && (flush_cycles != {CNT_W{1'b1}})) flush_cycles <= flush_cycles + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer
//   Scoreboard bench for pipeline_hazard_sequencer (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
//   Each stimulus row carries its expected control vector. The vector is pushed
//   when the row is driven and popped and compared mid-cycle.
//   Vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_bubble}.
module tb_pipeline_hazard_sequencer;

  localparam int CNT_W = 32;

  localparam logic [6:0] V_DEF  = 7'b1100110; // free running
  localparam logic [6:0] V_WAIT = 7'b0000001; // memory wait freeze
  localparam logic [6:0] V_RED  = 7'b1111110; // redirect cycle
  localparam logic [6:0] V_FL   = 7'b1110110; // flush-only cycle
  localparam logic [6:0] V_LU   = 7'b0001110; // load-use bubble
  localparam logic [6:0] V_RST  = 7'b0011001; // held in reset

  typedef struct packed {
    logic       lu;
    logic       rd;
    logic       mreq;
    logic       mrdy;
    logic [6:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use_stall = 1'b0;
  logic redirect = 1'b0;
  logic mem_req = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_bubble, mem_error;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;
  logic [6:0] obs;

  row_t       stim_q[$];
  logic [6:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign obs = {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_bubble};

  pipeline_hazard_sequencer #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_use_stall(load_use_stall),
    .redirect      (redirect),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_we         (pc_we),
    .ifid_we       (ifid_we),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .idex_we       (idex_we),
    .exmem_we      (exmem_we),
    .memwb_bubble  (memwb_bubble),
    .mem_error     (mem_error),
    .stall_cycles  (stall_cycles),
    .flush_cycles  (flush_cycles)
  );

  task automatic add(input logic lu, input logic rd, input logic mreq, input logic mrdy,
                     input logic [6:0] exp);
    stim_q.push_back('{lu: lu, rd: rd, mreq: mreq, mrdy: mrdy, exp: exp});
  endtask

  task automatic drive(input row_t r);
    load_use_stall = r.lu;
    redirect       = r.rd;
    mem_req        = r.mreq;
    mem_ready      = r.mrdy;
    exp_q.push_back(r.exp);
  endtask

  task automatic idle_inputs();
    load_use_stall = 1'b0;
    redirect       = 1'b0;
    mem_req        = 1'b0;
    mem_ready      = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    int cyc;
    // Outputs during the power-on reset.
    #1;
    checks++;
    if (obs !== V_RST) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b expected=%b", obs, V_RST);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Enter MEM_WAIT, then assert reset in the middle of a wait cycle.
    add(0, 0, 0, 0, V_DEF);
    add(0, 0, 1, 0, V_WAIT);
    add(0, 0, 1, 0, V_WAIT);
    cyc = 0;
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_prewait c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_RST) begin
      errors++;
      $display("FAIL reset_async: outputs=%b expected=%b", obs, V_RST);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_error: mem_error=%b expected=0", mem_error);
    end
    // A load-use bubble only occurs in RUN; a leftover MEM_WAIT would release instead.
    add(1, 0, 0, 0, V_LU);
    add(0, 0, 0, 0, V_DEF);
    cyc = 0;
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_run c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    logic [6:0] e;
    int cyc = 0;
    add(1, 0, 0, 0, V_LU);
    add(0, 0, 0, 0, V_DEF);
    add(0, 0, 0, 0, V_DEF);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_use c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_redirect();
    logic [6:0] e;
    int cyc = 0;
    add(0, 1, 0, 0, V_RED);
    add(0, 0, 0, 0, V_FL);
    add(0, 0, 0, 0, V_DEF);
    // A second redirect inside FLUSH reloads the countdown.
    add(0, 1, 0, 0, V_RED);
    add(0, 1, 0, 0, V_RED);
    add(0, 0, 0, 0, V_FL);
    add(0, 0, 0, 0, V_DEF);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL redirect c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_wait();
    logic [6:0] e;
    int cyc = 0;
    // Redirect held during the wait is ignored, including on the release cycle.
    add(0, 1, 1, 0, V_WAIT);
    add(0, 1, 1, 0, V_WAIT);
    add(1, 1, 1, 0, V_WAIT);
    add(0, 1, 1, 1, V_DEF);
    add(0, 1, 0, 0, V_RED);
    add(0, 0, 0, 0, V_FL);
    add(0, 0, 0, 0, V_DEF);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mem_wait c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (mem_error !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_no_error: mem_error=%b expected=0", mem_error);
    end
  endtask

  task automatic test_priority();
    logic [6:0] e;
    int cyc = 0;
    add(1, 1, 0, 0, V_RED);  // redirect beats load-use
    add(1, 0, 0, 0, V_FL);   // load-use ignored while flushing
    add(1, 0, 0, 0, V_LU);   // back in RUN
    add(0, 0, 0, 0, V_DEF);
    add(1, 1, 1, 0, V_WAIT); // memory wait beats everything
    add(0, 0, 1, 1, V_DEF);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL priority c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush_resume();
    logic [6:0] e;
    int cyc = 0;
    add(0, 1, 0, 0, V_RED);
    add(0, 0, 1, 0, V_WAIT);
    add(0, 0, 1, 0, V_WAIT);
    add(0, 0, 1, 1, V_DEF);
    add(0, 0, 0, 0, V_FL);   // remaining flush cycle resumes
    add(0, 0, 0, 0, V_DEF);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL flush_resume c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_watchdog();
    logic [6:0] e;
    int cyc = 0;
    pulse_reset();
    add(0, 0, 1, 0, V_WAIT);
    add(0, 0, 1, 0, V_WAIT);
    add(0, 0, 1, 0, V_WAIT);
    add(0, 0, 1, 0, V_WAIT);
    add(0, 0, 1, 0, V_DEF);  // timeout releases as if mem_ready were high
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL watchdog c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (mem_error !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_error: mem_error=%b expected=1", mem_error);
    end
`ifdef PERF_COUNTERS_EN
    checks++;
    if (stall_cycles !== 32'd4) begin
      errors++;
      $display("FAIL watchdog_stall_cnt: stall_cycles=%0d expected=4", stall_cycles);
    end
    checks++;
    if (flush_cycles !== 32'd0) begin
      errors++;
      $display("FAIL watchdog_flush_cnt: flush_cycles=%0d expected=0", flush_cycles);
    end
`endif
    // Back in RUN (load-use responds); the error stays sticky.
    add(1, 0, 0, 0, V_LU);
    add(0, 0, 0, 0, V_DEF);
    add(0, 0, 1, 1, V_DEF);
    cyc = 0;
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL watchdog_run c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (mem_error !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_sticky: mem_error=%b expected=1", mem_error);
    end
    pulse_reset();
    checks++;
    if (mem_error !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_clear: mem_error=%b expected=0", mem_error);
    end
  endtask

`ifdef PERF_COUNTERS_EN
  task automatic test_counters();
    logic [6:0] e;
    int cyc = 0;
    pulse_reset();
    add(1, 0, 0, 0, V_LU);   // stall 1
    add(0, 1, 0, 0, V_RED);  // flush 1
    add(0, 0, 0, 0, V_FL);   // flush 2
    add(0, 0, 1, 0, V_WAIT); // stall 2
    add(0, 0, 1, 1, V_DEF);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL counters c%0d: outputs=%b expected=%b", cyc, obs, e);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (stall_cycles !== 32'd2 || flush_cycles !== 32'd2) begin
      errors++;
      $display("FAIL counters_value: stall=%0d flush=%0d expected stall=2 flush=2",
               stall_cycles, flush_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_priority();
    test_flush_resume();
`ifdef PERF_COUNTERS_EN
    test_counters();
`endif
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
